// File: rtl/button_pkg.sv
// Shared definitions for button event decoding: FSM state encoding and
// default hold/repeat timings shared with the stopwatch top.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    localparam int HOLD_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on an already-synchronous level. The history register
// resets high so a level that is already high at reset never reports an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;

endmodule

// File: rtl/button_event.sv
// Debounced button level to registered press/release/long-press/repeat strobes.
// release and repeat are language keywords, so those ports are btn_release/btn_repeat.
module button_event
    import button_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic en,
    output logic press,
    output logic btn_release,
    output logic long_press,
    output logic btn_repeat,
    output logic held
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    btn_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             rise;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .level (btn_level),
        .rise  (rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            press       <= 1'b0;
            btn_release <= 1'b0;
            long_press  <= 1'b0;
            btn_repeat  <= 1'b0;
            held        <= 1'b0;
        end else begin
            press       <= 1'b0;
            btn_release <= 1'b0;
            long_press  <= 1'b0;
            btn_repeat  <= 1'b0;
            if (!en) begin
                // Disabling abandons any hold silently: no release is reported.
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                held      <= 1'b0;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        if (rise) begin
                            press     <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= ST_PRESSED;
                            held      <= 1'b1;
                        end else begin
                            held <= 1'b0;
                        end
                    end
                    ST_PRESSED: begin
                        if (!btn_level) begin
                            btn_release <= 1'b1;
                            state_reg   <= ST_IDLE;
                            held        <= 1'b0;
                        end else if (cnt_reg == HOLD_LAST) begin
                            long_press <= 1'b1;
                            cnt_reg    <= '0;
                            state_reg  <= ST_HELD;
                            held       <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                            held    <= 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!btn_level) begin
                            btn_release <= 1'b1;
                            state_reg   <= ST_IDLE;
                            held        <= 1'b0;
                        end else if (cnt_reg == REPEAT_LAST) begin
                            btn_repeat <= 1'b1;
                            cnt_reg    <= '0;
                            held       <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                            held    <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        held      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event with HOLD_CYCLES=8, REPEAT_CYCLES=4,
// comparing every cycle against a hold-duration reference model.
module tb_button_event;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst_n, btn_level, en;
    logic press, btn_release, long_press, btn_repeat, held;

    button_event #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_level   (btn_level),
        .en          (en),
        .press       (press),
        .btn_release (btn_release),
        .long_press  (long_press),
        .btn_repeat  (btn_repeat),
        .held        (held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: tracks how many edges the button has been held since press.
    logic       m_prev   = 1'b1;
    logic       m_active = 1'b0;
    int         m_k      = 0;
    logic [4:0] exp_vec  = '0;   // {press, release, long_press, repeat, held}
    logic [4:0] obs;
    assign obs = {press, btn_release, long_press, btn_repeat, held};

    task automatic step(input logic r, input logic e, input logic b);
        rst_n     = r;
        en        = e;
        btn_level = b;
        @(posedge clk);
        cyc++;
        exp_vec = '0;
        if (!r) begin
            m_prev   = 1'b1;
            m_active = 1'b0;
            m_k      = 0;
        end else begin
            if (!e) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (b && !m_prev) begin
                    m_active   = 1'b1;
                    m_k        = 0;
                    exp_vec[4] = 1'b1;
                end
            end else if (!b) begin
                m_active   = 1'b0;
                exp_vec[3] = 1'b1;
            end else begin
                m_k++;
                if (m_k == HOLD)
                    exp_vec[2] = 1'b1;
                else if (m_k > HOLD && ((m_k - HOLD) % REP) == 0)
                    exp_vec[1] = 1'b1;
            end
            exp_vec[0] = m_active;
            m_prev     = b;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            step(i >= 3, 1'b1, i < 9);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL reset_cycle%0d: got %b expected %b", i, obs, exp_vec);
            end
            total++;
            if ({press, btn_release, held} !== 3'b000) begin
                bad++;
                $display("FAIL reset_quiet%0d: got press/rel/held=%b expected 000", i,
                         {press, btn_release, held});
            end
        end
    endtask

    task automatic test_short_press();
        int t_p = -1, t_r = -1, n_long = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, i >= 2 && i < 5);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL short_cycle%0d: got %b expected %b", i, obs, exp_vec);
            end
            if (press) t_p = cyc;
            if (btn_release) t_r = cyc;
            if (long_press) n_long++;
        end
        total++;
        if (t_p < 0 || t_r - t_p != 3 || n_long != 0) begin
            bad++;
            $display("FAIL short_timing: got release-press=%0d long=%0d expected 3 and 0",
                     t_r - t_p, n_long);
        end
    endtask

    task automatic test_long_hold();
        int t_p = -1, t_l = -1, t_r = -1, n_rep = 0;
        int rep_t[2] = '{-1, -1};
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, i >= 1 && i < 21);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL long_cycle%0d: got %b expected %b", i, obs, exp_vec);
            end
            if (press) t_p = cyc;
            if (long_press) t_l = cyc;
            if (btn_release) t_r = cyc;
            if (btn_repeat) begin
                if (n_rep < 2) rep_t[n_rep] = cyc;
                n_rep++;
            end
        end
        total++;
        if (t_p < 0 || t_l - t_p != 8 || t_r - t_p != 20 || n_rep != 2 ||
            rep_t[0] - t_p != 12 || rep_t[1] - t_p != 16) begin
            bad++;
            $display("FAIL long_timing: got long=%0d rep=%0d,%0d rel=%0d nrep=%0d expected 8 12,16 20 2",
                     t_l - t_p, rep_t[0] - t_p, rep_t[1] - t_p, t_r - t_p, n_rep);
        end
    endtask

    task automatic test_simultaneous();
        // First the long_press boundary (8 high cycles), then the repeat boundary (12).
        for (int s = 0; s < 2; s++) begin
            int hi = (s == 0) ? HOLD : HOLD + REP;
            int n_long = 0, n_rep = 0, n_rel = 0;
            for (int i = 0; i < hi + 4; i++) begin
                step(1'b1, 1'b1, i >= 1 && i < hi + 1);
                total++;
                if (obs !== exp_vec) begin
                    bad++;
                    $display("FAIL simul%0d_cycle%0d: got %b expected %b", s, i, obs, exp_vec);
                end
                if (long_press) n_long++;
                if (btn_repeat) n_rep++;
                if (btn_release) n_rel++;
            end
            total++;
            if (n_rel != 1 || n_rep != 0 || n_long != s) begin
                bad++;
                $display("FAIL simul%0d_counts: got rel=%0d long=%0d rep=%0d expected 1 %0d 0",
                         s, n_rel, n_long, n_rep, s);
            end
        end
    endtask

    task automatic test_en_drop();
        int n_press = 0, n_rel = 0, n_rep = 0;
        for (int i = 0; i < 28; i++) begin
            logic e, b;
            e = !(i >= 12 && i < 15);
            b = (i >= 1 && i < 22) || (i >= 24);
            step(1'b1, e, b);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL endrop_cycle%0d: got %b expected %b", i, obs, exp_vec);
            end
            if (i >= 12 && i < 22) begin
                if (press) n_press++;
                if (btn_release) n_rel++;
                if (btn_repeat) n_rep++;
                total++;
                if (held !== 1'b0) begin
                    bad++;
                    $display("FAIL endrop_held%0d: got %b expected 0", i, held);
                end
            end
        end
        total++;
        if (n_press != 0 || n_rel != 0 || n_rep != 0 || held !== 1'b1) begin
            bad++;
            $display("FAIL endrop_counts: got press=%0d rel=%0d rep=%0d held=%b expected 0 0 0 1",
                     n_press, n_rel, n_rep, held);
        end
        step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_held();
        int n_press = 0;
        for (int i = 0; i < 22; i++) begin
            step(i != 12, 1'b1, i >= 1 && i < 20);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL rstheld_cycle%0d: got %b expected %b", i, obs, exp_vec);
            end
            if (i == 12) begin
                total++;
                if (obs !== 5'b00000) begin
                    bad++;
                    $display("FAIL rstheld_clear: got %b expected 00000", obs);
                end
            end
            if (i > 12 && press) n_press++;
        end
        total++;
        if (n_press != 0) begin
            bad++;
            $display("FAIL rstheld_nopress: got %0d presses expected 0", n_press);
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        logic e = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            logic r;
            if ($urandom_range(0, 9) == 0) b = ~b;
            if ($urandom_range(0, 59) == 0) e = ~e;
            r = ($urandom_range(0, 199) != 0);
            step(r, e, b);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, obs, exp_vec);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        btn_level = 1'b0;
        test_reset();
        test_short_press();
        test_long_hold();
        test_simultaneous();
        test_en_drop();
        test_reset_mid_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event.md
# button_event

Turns one debounced button level into registered single-cycle event strobes: press, release, long-press, and auto-repeat while held. It sits directly downstream of the button debouncer, one instance per button. Its outputs drive the stopwatch control logic (pause, reset, adjust-mode increment), so consumers never do their own edge detection or hold timing.

## Interface
- HOLD_CYCLES, 50_000_000: cycles a press must be held before `long_press` fires; must be ≥ 2.
- REPEAT_CYCLES, 10_000_000: period of `repeat` strobes after `long_press`; must be ≥ 2.
- CNT_W, 32: counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES) − 1.
- clk  in  1  single system clock; everything is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- btn_level  in  1  debounced button level from the debouncer; already synchronous to `clk`.
- en  in  1  event enable; low forces idle and suppresses all strobes.
- press  out  1  one-cycle strobe on a qualified rising edge.
- release  out  1  one-cycle strobe when the button is let go after a press.
- long_press  out  1  one-cycle strobe after HOLD_CYCLES of continuous hold.
- repeat  out  1  one-cycle strobe every REPEAT_CYCLES after `long_press` while the button stays held.
- held  out  1  level; high while the FSM is in PRESSED or HELD.

## Operation
- **Input tracking:** `prev` register holds last sampled `btn_level`.
  - Updated every cycle, including while `en` is low.
  - Reset value is 1, so a button held through reset never produces `press`.
- **FSM states:** IDLE, PRESSED, HELD. Down-counter-free design: `cnt` counts up from 0.
- **IDLE:**
  - If `en` and `btn_level` and not `prev`: assert `press`, set `cnt` to 0, go to PRESSED.
  - Otherwise stay in IDLE.
- **PRESSED:**
  - If `btn_level` is 0: assert `release`, go to IDLE.
  - Else if `cnt` equals HOLD_CYCLES−1: assert `long_press`, set `cnt` to 0, go to HELD.
  - Else increment `cnt`.
- **HELD:**
  - If `btn_level` is 0: assert `release`, go to IDLE.
  - Else if `cnt` equals REPEAT_CYCLES−1: assert `repeat`, set `cnt` to 0.
  - Else increment `cnt`.
- **Priority:** release beats `long_press`/`repeat` in the same cycle. At most one strobe is high in any cycle.
- **en low:**
  - Next state is IDLE and `cnt` is 0.
  - All strobes and `held` are 0; no `release` is emitted.
  - After `en` returns high, a new rising edge is required to produce `press`.
- **Reset:** state IDLE, `cnt` 0, `prev` 1, all outputs 0. Reset overrides everything, mid-hold included.
- `held` is registered and equals (next state ≠ IDLE).

## Timing
- All outputs are registered: latency is 1 cycle from the sampled input to the output.
- If `btn_level` is first sampled high at edge e0, then:
  - `press` is high during the cycle after e0;
  - `long_press` is high exactly HOLD_CYCLES cycles later;
  - `repeat` is high at +REPEAT_CYCLES, +2·REPEAT_CYCLES, and so on after `long_press`.
- `release` is high during the cycle after the first edge that samples `btn_level` = 0 while in PRESSED or HELD.
- Strobes are exactly one cycle wide, with no back-to-back repeats: REPEAT_CYCLES ≥ 2 guarantees this.
- `held` rises in the same cycle as `press` and falls in the same cycle as `release` (or the cycle after `en` or `rst_n` drops).

## Structure
- Shared package `button_pkg` holds:
  - state encoding IDLE/PRESSED/HELD as a 2-bit typedef;
  - default constants HOLD_CYCLES_DEF and REPEAT_CYCLES_DEF, reused by the stopwatch top.
- One natural sub-module: `rise_detect`, containing `prev` register plus the rising-edge term with reset-to-1 behaviour, reusable for other level inputs.
- The FSM, counter and output registers stay in `button_event`.

## Test plan
All scenarios use HOLD_CYCLES=8 and REPEAT_CYCLES=4.
- **Reset with button held:** hold `btn_level`=1 through `rst_n` deassertion, then drop it → `press`, `release` and `held` stay 0 throughout.
- **Short press:** `btn_level` high for 3 cycles → one `press` at T, `release` at T+3, `held` high T..T+2, no `long_press`.
- **Long hold:** `btn_level` high for 20 cycles → `press` at T, `long_press` at T+8, `repeat` at T+12 and T+16, `release` at T+20.
- **Simultaneous events:** `btn_level` falls on the edge where `cnt` would reach 7 → `release` only, no `long_press`; repeat the check at a `repeat` boundary.
- **en dropped mid-HELD:** `held` drops next cycle, with no `release` and no further `repeat`. Raise `en` with the button still high → no `press` until the button falls and rises again.
- **Reset mid-HELD:** `rst_n` low for 1 cycle → all outputs 0 next cycle, and no `press` while the button stays high afterwards.
